uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter producing standard 8N1/8E1/8O1 frames (optional second stop bit) on a single line.
- Bit timing is set by a clock-cycles-per-bit parameter.
- Sits between game/host logic and the FPGA TX pin; pairs with the project's UART receiver at the same c_CYCLES_PER_BIT.
- Byte-wide valid/ready handshake on the parallel side.

Parameters:
- c_CYCLES_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
- c_STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- i_CLK  input  1  system clock.
- i_RST  input  1  reset; synchronous, active-high.
- i_TX_DV  input  1  data valid; byte is accepted on any edge where i_TX_DV=1 and o_TX_READY=1.
- i_TX_BYTE  input  8  byte to send, LSB first.
- i_PARITY_EN  input  1  1 = append parity bit after data.
- i_PARITY_ODD  input  1  1 = odd parity, 0 = even; ignored when i_PARITY_EN=0.
- o_TX_SERIAL  output  1  serial line; idles high.
- o_TX_ACTIVE  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_TX_READY  output  1  high only in IDLE.
- o_TX_DONE  output  1  one-cycle pulse on the first IDLE cycle after a frame completes.

Behaviour:
- Reset (i_RST=1 at an edge), regardless of state:
  - State -> IDLE; counter and bit index cleared.
  - o_TX_SERIAL=1, o_TX_ACTIVE=0, o_TX_READY=1, o_TX_DONE=0.
  - A frame in flight is abandoned with no DONE pulse. The line may show a truncated start or data bit; that is acceptable.
- Accept:
  - In IDLE with i_TX_DV=1, register i_TX_BYTE, i_PARITY_EN and i_PARITY_ODD.
  - Parity is computed from the registered byte: XOR of the 8 bits, XORed with the odd flag.
  - Next state is START. Inputs are not sampled again until the next IDLE.
- Latency: o_TX_SERIAL goes low on the edge after the accept edge (1 cycle).
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: drive 0 for c_CYCLES_PER_BIT cycles.
  - DATA: drive bit[index] for c_CYCLES_PER_BIT cycles per bit. Index runs 0..7 and does not wrap; after bit 7 go to PARITY if enabled, else STOP.
  - PARITY: drive the parity bit for c_CYCLES_PER_BIT cycles.
  - STOP: drive 1 for c_STOP_BITS*c_CYCLES_PER_BIT cycles, then go to IDLE.
  - Any illegal state encoding -> IDLE.
- Counter:
  - Width is $clog2(c_CYCLES_PER_BIT*2); counts 0..c_CYCLES_PER_BIT-1.
  - Clears on each bit boundary; no drift across the frame.
- Frame length: (10 + P + (c_STOP_BITS-1)) * c_CYCLES_PER_BIT cycles, where P = 1 if parity is enabled, else 0.
- DONE / back-to-back:
  - o_TX_DONE=1 and o_TX_READY=1 in the same first IDLE cycle.
  - A DV in that cycle is accepted, so consecutive frames have no extra idle gap.
- i_TX_DV while busy is ignored; the byte is not queued.
- Outputs are registered; no combinational path from inputs to o_TX_SERIAL.

Decomposition:
- Shared package `uart_pkg`:
  - One-hot state constants, shared with the receiver.
  - Default c_CYCLES_PER_BIT.
  - Data width 8.
- Single module; no sub-module needed.
- The bit-period counter may be a small `uart_baud_cnt` shared with the RX if the team chooses to factor it out.

Test Plan (c_CYCLES_PER_BIT=4 unless noted):
- Reset then idle: hold i_RST 3 cycles -> o_TX_SERIAL=1, READY=1, ACTIVE=0, DONE=0; with no DV, line stays 1 for 100 cycles.
- 0xA5, no parity:
  - Line, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - ACTIVE high 40 cycles; DONE pulses once at cycle 41 after accept.
  - An RX model decodes 0xA5.
- Parity:
  - 0xA5 even -> parity bit 0; 0xA5 odd -> parity bit 1; 0x01 even -> parity bit 1.
  - Frame is 44 cycles.
  - c_STOP_BITS=2 adds 4 high cycles.
- Back-to-back and busy:
  - Send 0x3C then 0xC3 with DV asserted in the DONE cycle -> second start bit begins the next cycle.
  - A DV pulse with 0xFF mid-frame is ignored; only 0x3C and 0xC3 are decoded.
- Reset mid-frame: assert i_RST during DATA bit 3 -> line is 1 on the next cycle, READY=1, no DONE; a following 0x55 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, one-hot state encoding and parity helper
package uart_pkg;

    localparam int c_DEFAULT_CYCLES_PER_BIT = 434;
    localparam int c_DATA_W                 = 8;
    localparam int c_IDX_W                  = $clog2(c_DATA_W);

    // One-hot encoding, also used by the receiver
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } uart_state_t;

    function automatic logic calc_parity(input logic [c_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter; tick marks the last cycle of each serial bit
module uart_baud_cnt #(
    parameter int c_CYCLES_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(c_CYCLES_PER_BIT * 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(c_CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Wraps exactly on each bit boundary so the frame cannot drift
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with optional parity and one or two stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT,
    parameter int c_STOP_BITS      = 1
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_TX_DV,
    input  logic [c_DATA_W-1:0] i_TX_BYTE,
    input  logic                i_PARITY_EN,
    input  logic                i_PARITY_ODD,
    output logic                o_TX_SERIAL,
    output logic                o_TX_ACTIVE,
    output logic                o_TX_READY,
    output logic                o_TX_DONE
);

    localparam logic [c_IDX_W-1:0] LAST_DATA = c_IDX_W'(c_DATA_W - 1);
    localparam logic [c_IDX_W-1:0] LAST_STOP = c_IDX_W'(c_STOP_BITS - 1);

    uart_state_t         state, state_next;
    logic [c_DATA_W-1:0] data_q, data_next;
    logic                par_en_q, par_en_next;
    logic                odd_q, odd_next;
    logic [c_IDX_W-1:0]  idx, idx_next;
    logic                serial_next;
    logic                done_next;
    logic                bit_tick;

    uart_baud_cnt #(
        .c_CYCLES_PER_BIT(c_CYCLES_PER_BIT)
    ) u_baud (
        .clk (i_CLK),
        .rst (i_RST),
        .clr (state == ST_IDLE),
        .tick(bit_tick)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state       <= ST_IDLE;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            idx         <= '0;
            o_TX_SERIAL <= 1'b1;
            o_TX_ACTIVE <= 1'b0;
            o_TX_READY  <= 1'b1;
            o_TX_DONE   <= 1'b0;
        end else begin
            state       <= state_next;
            data_q      <= data_next;
            par_en_q    <= par_en_next;
            odd_q       <= odd_next;
            idx         <= idx_next;
            o_TX_SERIAL <= serial_next;
            o_TX_ACTIVE <= (state_next != ST_IDLE);
            o_TX_READY  <= (state_next == ST_IDLE);
            o_TX_DONE   <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        data_next   = data_q;
        par_en_next = par_en_q;
        odd_next    = odd_q;
        idx_next    = idx;
        done_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                idx_next = '0;
                if (i_TX_DV) begin
                    data_next   = i_TX_BYTE;
                    par_en_next = i_PARITY_EN;
                    odd_next    = i_PARITY_ODD;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx == LAST_DATA) begin
                        idx_next   = '0;
                        state_next = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_next = idx + c_IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // idx is reused to count stop bits
                if (bit_tick) begin
                    if (idx == LAST_STOP) begin
                        idx_next   = '0;
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + c_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Line level is decided from the next state so the output can be a plain flop
    always_comb begin
        serial_next = 1'b1;
        case (state_next)
            ST_START:  serial_next = 1'b0;
            ST_DATA:   serial_next = data_next[idx_next];
            ST_PARITY: serial_next = calc_parity(data_next, odd_next);
            default:   serial_next = 1'b1;
        endcase
    end

endmodule
